// File: rtl/imem_arbiter.sv
// ----------------------------------------------------------------------------
// imem_arbiter
//
// Purpose:
//   Shares a single-port, synchronous-read instruction memory between the
//   fetch stage (F) and the debug/loader read port (D). Each cycle it grants
//   at most one requester, drives that requester's address to the memory,
//   and tags the issued read. One cycle later it steers mem_dout back to the
//   owner. A per-requester hold register keeps a response that its owner
//   cannot accept yet, so rdata stays stable until it is accepted.
//
// Configuration macro:
//   IMEM_ARB_RR_EN - when defined, a tie between two eligible requesters is
//                    resolved round-robin. When undefined (default), F has
//                    fixed priority and a starvation counter forces a D grant
//                    after STARVE_MAX consecutive contended F wins.
//
// Ports:
//   clk                 system clock, all state updates on posedge
//   rst                 synchronous active-high reset
//   f_req / d_req       read request
//   f_addr / d_addr     word address of the request
//   f_gnt / d_gnt       request issued to memory this cycle (combinational)
//   f_rvalid / d_rvalid response valid
//   f_rdata / d_rdata   response data (zero when not valid)
//   f_rready / d_rready requester can accept the response
//   mem_addr            address to the instruction memory
//   mem_dout            memory read data for the previous cycle's mem_addr
// ----------------------------------------------------------------------------
module imem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              f_rready,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              d_rready,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic ID_F = 1'b0;
    localparam logic ID_D = 1'b1;

    // Issue tag: a read was sent to memory last cycle, and for whom
    logic              r_iss_v;
    logic              r_iss_id;
    // Hold registers for responses the owner has not accepted yet
    logic              r_f_hold_v;
    logic [DATA_W-1:0] r_f_hold;
    logic              r_d_hold_v;
    logic [DATA_W-1:0] r_d_hold;
    // Address presented to memory when nobody is granted
    logic [ADDR_W-1:0] r_last_addr;

    logic w_f_direct;
    logic w_d_direct;
    logic w_f_elig;
    logic w_d_elig;
    logic w_both;
    logic w_gnt_f;
    logic w_gnt_d;

    // Eligibility: no held response, and any in-flight read is being accepted now
    always_comb begin
        w_f_direct = r_iss_v && (r_iss_id == ID_F);
        w_d_direct = r_iss_v && (r_iss_id == ID_D);
        w_f_elig   = f_req && !r_f_hold_v && (!w_f_direct || f_rready);
        w_d_elig   = d_req && !r_d_hold_v && (!w_d_direct || d_rready);
        w_both     = w_f_elig && w_d_elig;
    end

`ifdef IMEM_ARB_RR_EN
    logic r_rr_last;

    // Round-robin tie break: the requester not served last wins
    always_comb begin
        w_gnt_f = 1'b0;
        w_gnt_d = 1'b0;
        if (w_both) begin
            if (r_rr_last == ID_F) begin
                w_gnt_d = 1'b1;
            end else begin
                w_gnt_f = 1'b1;
            end
        end else begin
            w_gnt_f = w_f_elig;
            w_gnt_d = w_d_elig;
        end
    end

    // Remember the owner of every grant, contended or not
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_last <= ID_D;
        end else if (w_gnt_f) begin
            r_rr_last <= ID_F;
        end else if (w_gnt_d) begin
            r_rr_last <= ID_D;
        end else begin
            r_rr_last <= r_rr_last;
        end
    end
`else
    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);

    logic [3:0] r_starve_cnt;

    // Fixed F priority, overridden once D has lost STARVE_MAX contended rounds
    always_comb begin
        w_gnt_f = 1'b0;
        w_gnt_d = 1'b0;
        if (w_both) begin
            if (r_starve_cnt == STARVE_MAX_C) begin
                w_gnt_d = 1'b1;
            end else begin
                w_gnt_f = 1'b1;
            end
        end else begin
            w_gnt_f = w_f_elig;
            w_gnt_d = w_d_elig;
        end
    end

    // Count consecutive contended F wins; any other outcome restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= 4'd0;
        end else if (w_both && w_gnt_f) begin
            if (r_starve_cnt == STARVE_MAX_C) begin
                r_starve_cnt <= r_starve_cnt;
            end else begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end
        end else begin
            r_starve_cnt <= 4'd0;
        end
    end
`endif

    // Grant outputs and memory address mux
    always_comb begin
        f_gnt = w_gnt_f;
        d_gnt = w_gnt_d;
        if (w_gnt_f) begin
            mem_addr = f_addr;
        end else if (w_gnt_d) begin
            mem_addr = d_addr;
        end else begin
            mem_addr = r_last_addr;
        end
    end

    // F response: hold register first, else the direct memory data.
    // Reset suppresses a response still in flight.
    always_comb begin
        if (rst) begin
            f_rvalid = 1'b0;
            f_rdata  = {DATA_W{1'b0}};
        end else if (r_f_hold_v) begin
            f_rvalid = 1'b1;
            f_rdata  = r_f_hold;
        end else if (w_f_direct) begin
            f_rvalid = 1'b1;
            f_rdata  = mem_dout;
        end else begin
            f_rvalid = 1'b0;
            f_rdata  = {DATA_W{1'b0}};
        end
    end

    // D response: same selection as F
    always_comb begin
        if (rst) begin
            d_rvalid = 1'b0;
            d_rdata  = {DATA_W{1'b0}};
        end else if (r_d_hold_v) begin
            d_rvalid = 1'b1;
            d_rdata  = r_d_hold;
        end else if (w_d_direct) begin
            d_rvalid = 1'b1;
            d_rdata  = mem_dout;
        end else begin
            d_rvalid = 1'b0;
            d_rdata  = {DATA_W{1'b0}};
        end
    end

    // Issue tag and last address; a grant in a reset cycle is not recorded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_iss_v     <= 1'b0;
            r_iss_id    <= ID_F;
            r_last_addr <= {ADDR_W{1'b0}};
        end else begin
            r_iss_v  <= w_gnt_f || w_gnt_d;
            r_iss_id <= w_gnt_d ? ID_D : ID_F;
            if (w_gnt_f || w_gnt_d) begin
                r_last_addr <= mem_addr;
            end else begin
                r_last_addr <= r_last_addr;
            end
        end
    end

    // F hold: capture an unaccepted direct response, release on acceptance
    always_ff @(posedge clk) begin
        if (rst) begin
            r_f_hold_v <= 1'b0;
            r_f_hold   <= {DATA_W{1'b0}};
        end else if (r_f_hold_v) begin
            r_f_hold_v <= !f_rready;
            r_f_hold   <= r_f_hold;
        end else if (w_f_direct && !f_rready) begin
            r_f_hold_v <= 1'b1;
            r_f_hold   <= mem_dout;
        end else begin
            r_f_hold_v <= 1'b0;
            r_f_hold   <= r_f_hold;
        end
    end

    // D hold: same behaviour as the F hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_hold_v <= 1'b0;
            r_d_hold   <= {DATA_W{1'b0}};
        end else if (r_d_hold_v) begin
            r_d_hold_v <= !d_rready;
            r_d_hold   <= r_d_hold;
        end else if (w_d_direct && !d_rready) begin
            r_d_hold_v <= 1'b1;
            r_d_hold   <= mem_dout;
        end else begin
            r_d_hold_v <= 1'b0;
            r_d_hold   <= r_d_hold;
        end
    end

endmodule

// File: tb/tb_imem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_imem_arbiter
//
// Table-driven bench for imem_arbiter. Each table row is one clock cycle of
// inputs plus the expected grants, rvalids and (optionally) mem_addr. Read
// data is checked through per-requester scoreboards: the expected word is
// queued when the row expects a grant and compared when the response shows.
// A synchronous-read memory model with a unique word per address sits on
// mem_addr/mem_dout.
// ----------------------------------------------------------------------------
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        f_req = 1'b0;
    logic [9:0]  f_addr = 10'd0;
    logic        f_gnt;
    logic        f_rvalid;
    logic [31:0] f_rdata;
    logic        f_rready = 1'b1;
    logic        d_req = 1'b0;
    logic [9:0]  d_addr = 10'd0;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        d_rready = 1'b1;
    logic [9:0]  mem_addr;
    logic [31:0] mem_dout = 32'd0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       f_req;
        logic [9:0] f_addr;
        logic       f_rdy;
        logic       d_req;
        logic [9:0] d_addr;
        logic       d_rdy;
        logic       e_fg;
        logic       e_dg;
        logic       e_fv;
        logic       e_dv;
        logic       chk_ma;
        logic [9:0] e_ma;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] fq[$];
    logic [31:0] dq[$];

    imem_arbiter #(
        .ADDR_W    (10),
        .DATA_W    (32),
        .STARVE_MAX(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .f_req   (f_req),
        .f_addr  (f_addr),
        .f_gnt   (f_gnt),
        .f_rvalid(f_rvalid),
        .f_rdata (f_rdata),
        .f_rready(f_rready),
        .d_req   (d_req),
        .d_addr  (d_addr),
        .d_gnt   (d_gnt),
        .d_rvalid(d_rvalid),
        .d_rdata (d_rdata),
        .d_rready(d_rready),
        .mem_addr(mem_addr),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_val(input logic [9:0] a);
        return {6'h2B, a, 6'h15, ~a};
    endfunction

    // Synchronous-read instruction memory
    always @(posedge clk) mem_dout <= mem_val(mem_addr);

    task automatic check(input string name, input int row,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic fr, input logic [9:0] fa,
                       input logic fy, input logic dr, input logic [9:0] da,
                       input logic dy, input logic efg, input logic edg,
                       input logic efv, input logic edv, input logic cm,
                       input logic [9:0] ema);
        vec_t v;
        v.rst = r;    v.f_req = fr; v.f_addr = fa; v.f_rdy = fy;
        v.d_req = dr; v.d_addr = da; v.d_rdy = dy;
        v.e_fg = efg; v.e_dg = edg; v.e_fv = efv; v.e_dv = edv;
        v.chk_ma = cm; v.e_ma = ema;
        vecs.push_back(v);
    endtask

    initial begin
        logic pf;
        logic pd;
        logic gf;
        logic gd;
        vec_t v;

        // ---- reset ----
        add(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        add(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        // ---- F alone, back to back 0..3 ----
        add(1'b0, 1'b1, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        add(1'b0, 1'b1, 10'h001, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h001);
        add(1'b0, 1'b1, 10'h002, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h002);
        add(1'b0, 1'b1, 10'h003, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 10'h003);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h003);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        // ---- F 0x010 held for 3 cycles while D keeps the memory busy ----
        add(1'b0, 1'b1, 10'h010, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h010);
        add(1'b0, 1'b1, 10'h011, 1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h010);
        add(1'b0, 1'b1, 10'h011, 1'b0, 1'b1, 10'h300, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 10'h300);
        add(1'b0, 1'b1, 10'h011, 1'b0, 1'b1, 10'h301, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10'h301);
        add(1'b0, 1'b1, 10'h011, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h301);
        add(1'b0, 1'b1, 10'h011, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h011);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000);
        // ---- contention from a fresh reset ----
        add(1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        pf = 1'b0;
        pd = 1'b0;
        for (int i = 0; i < 10; i++) begin
`ifdef IMEM_ARB_RR_EN
            gf = ((i % 2) == 0);
`else
            gf = ((i % 5) != 4);
`endif
            gd = !gf;
            add(1'b0, 1'b1, 10'(10'h100 + i), 1'b1, 1'b1, 10'(10'h200 + i), 1'b1,
                gf, gd, pf, pd, 1'b1, gf ? 10'(10'h100 + i) : 10'(10'h200 + i));
            pf = gf;
            pd = gd;
        end
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, pf, pd, 1'b0, 10'h000);
        // ---- idle after a grant to 0x2A0 ----
        add(1'b0, 1'b1, 10'h2A0, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2A0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h2A0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2A0);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h2A0);
        // ---- D held while F reads through the memory ----
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h3FF, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3FF);
        add(1'b0, 1'b1, 10'h020, 1'b1, 1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 10'h020);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 10'h020);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'h020);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h020);
        // ---- reset right after a D grant, with an F grant in the reset cycle ----
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b1, 10'h155, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10'h155);
        add(1'b1, 1'b1, 10'h009, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10'h000);
        add(1'b0, 1'b1, 10'h007, 1'b1, 1'b0, 10'h000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 10'h007);
        add(1'b0, 1'b0, 10'h000, 1'b1, 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 10'h007);

        @(posedge clk);
        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v        = vecs[i];
            rst      = v.rst;
            f_req    = v.f_req;
            f_addr   = v.f_addr;
            f_rready = v.f_rdy;
            d_req    = v.d_req;
            d_addr   = v.d_addr;
            d_rready = v.d_rdy;
            @(negedge clk);
            check("f_gnt", i, 32'(f_gnt), 32'(v.e_fg));
            check("d_gnt", i, 32'(d_gnt), 32'(v.e_dg));
            check("f_rvalid", i, 32'(f_rvalid), 32'(v.e_fv));
            check("d_rvalid", i, 32'(d_rvalid), 32'(v.e_dv));
            if (v.chk_ma) check("mem_addr", i, 32'(mem_addr), 32'(v.e_ma));
            if (v.e_fv) begin
                if (fq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL f_scoreboard row=%0d got=rvalid expected=queued read", i);
                end else begin
                    check("f_rdata", i, f_rdata, fq[0]);
                    if (v.f_rdy) void'(fq.pop_front());
                end
            end else begin
                check("f_rdata_idle", i, f_rdata, 32'h0);
            end
            if (v.e_dv) begin
                if (dq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL d_scoreboard row=%0d got=rvalid expected=queued read", i);
                end else begin
                    check("d_rdata", i, d_rdata, dq[0]);
                    if (v.d_rdy) void'(dq.pop_front());
                end
            end else begin
                check("d_rdata_idle", i, d_rdata, 32'h0);
            end
            if (v.rst) begin
                fq.delete();
                dq.delete();
            end else begin
                if (v.e_fg) fq.push_back(mem_val(v.f_addr));
                if (v.e_dg) dq.push_back(mem_val(v.d_addr));
            end
            @(posedge clk);
            #1;
        end

        check("f_sb_drained", 0, 32'(fq.size()), 32'd0);
        check("d_sb_drained", 0, 32'(dq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
